// File: rtl/apb_arb_pkg.sv
// Shared state encoding and defaults for the APB configuration-port arbiter.
// Optional ACCESS timeout is enabled by defining APB_TIMEOUT_EN.
package apb_arb_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} apb_st_e;

  localparam int DEF_TIMEOUT_CYC = 256;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: combinational one-hot grant, pointer advances only on accept.
// Latency: grant is same-cycle; backpressure: pointer holds while accept is low.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [N-1:0]         req,
  input  logic                 accept,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] last_ptr;
  logic [IW-1:0] idx;
  logic          found;

  // Search starts one past the previous winner, so the previous winner ranks last.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int i = 1; i <= N; i++) begin
      idx = IW'((int'(last_ptr) + i) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      last_ptr <= IW'(N - 1);
    end else if (accept) begin
      last_ptr <= grant_idx;
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// Shares one APB master port among NUM_REQ requesters (round-robin); APB_TIMEOUT_EN adds an ACCESS timeout.
// Latency: accept at T -> SETUP T+1 -> ACCESS T+2 -> rsp_valid no earlier than T+3.
// Backpressure: req_ready only in IDLE or on the completing ACCESS cycle; ACCESS holds until pready.
`ifndef APB_DEPTH
`define APB_DEPTH 12
`endif
`ifndef APB_WIDTH
`define APB_WIDTH 32
`endif

module apb_master_arbiter
  import apb_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = `APB_DEPTH,
  parameter int DATA_W  = `APB_WIDTH
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int IDX_W = $clog2(NUM_REQ);

  apb_st_e            state_q, state_d;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] owner_q;
  logic [IDX_W-1:0]   win_idx;
  logic               can_accept;
  logic               accept;
  logic               done;
  logic               abort;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .pclk      (pclk),
    .presetn   (presetn),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (win_idx)
  );

  // Accepting on the completing ACCESS cycle gives back-to-back transfers with no idle gap.
  assign can_accept = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && pready);
  assign accept     = can_accept && (|grant);
  assign req_ready  = presetn ? (grant & {NUM_REQ{can_accept}}) : '0;
  assign done       = (state_q == ST_ACCESS) && pready;

  assign psel    = (state_q != ST_IDLE);
  assign penable = (state_q == ST_ACCESS);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (pready)     state_d = accept ? ST_SETUP : ST_IDLE;
        else if (abort) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= ST_IDLE;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      owner_q   <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      rsp_valid <= '0;
      if (accept) begin
        paddr   <= req_addr[win_idx*ADDR_W +: ADDR_W];
        pwdata  <= req_wdata[win_idx*DATA_W +: DATA_W];
        pwrite  <= req_write[win_idx];
        owner_q <= grant;
      end
      // owner_q still names the finishing transfer here even if a new one is accepted.
      if (done) begin
        rsp_valid <= owner_q;
        rsp_rdata <= pwrite ? '0 : prdata;
      end else if (abort) begin
        rsp_valid <= owner_q;
        rsp_rdata <= '0;
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] tcnt_q;

  assign abort = (state_q == ST_ACCESS) && !pready && (tcnt_q == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      tcnt_q  <= '0;
      rsp_err <= 1'b0;
    end else begin
      if (state_q == ST_SETUP) begin
        tcnt_q <= '0;
      end else if ((state_q == ST_ACCESS) && !pready) begin
        tcnt_q <= tcnt_q + 1'b1;
      end
      if (done) begin
        rsp_err <= 1'b0;
      end else if (abort) begin
        rsp_err <= 1'b1;
      end
    end
  end
`else
  assign abort   = 1'b0;
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed and randomized checks of apb_master_arbiter against a transaction-level model.
// Timeout scenarios are included when APB_TIMEOUT_EN is defined.
module tb_apb_master_arbiter;
    localparam int NR = 4;
    localparam int AW = 12;
    localparam int DW = 32;

    logic             pclk = 1'b0;
    logic             presetn;
    logic [NR-1:0]    req_valid, req_ready, req_write, rsp_valid;
    logic [NR*AW-1:0] req_addr;
    logic [NR*DW-1:0] req_wdata;
    logic [DW-1:0]    rsp_rdata, pwdata, prdata;
    logic             rsp_err, pwrite, psel, penable, pready;
    logic [AW-1:0]    paddr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 pclk = ~pclk;

    apb_master_arbiter #(
        .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)
`ifdef APB_TIMEOUT_EN
        , .TIMEOUT_CYC(8)
`endif
    ) dut (
        .pclk(pclk), .presetn(presetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel(psel), .penable(penable), .pready(pready), .prdata(prdata)
    );

    task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
        n_chk++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        presetn   = 1'b0;
        req_valid = '0;
        pready    = 1'b0;
        repeat (2) tick();
        presetn = 1'b1;
    endtask

    int k, last_t, acc, win, m_last, age, cur_owner, rsp_own, exp_ready;
    logic [NR-1:0] mv;
    logic act, done, free, rsp_pend, cur_wr;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wd, rsp_dat;
    logic          m_wr[NR];
    logic [AW-1:0] m_addr[NR];
    logic [DW-1:0] m_wd[NR];

    initial begin
        presetn = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
        pready = 1'b0; prdata = '0;

        // Reset state, with every requester asking
        req_valid = 4'b1111;
        tick(); settle();
        chk("rst_ready", req_ready, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_rdata", rsp_rdata, 0);
        chk("rst_rsp_err", rsp_err, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_pwrite", pwrite, 0);

        // 1: single write from req0, latency T / T+1 / T+2 / T+3
        do_reset();
        set_req(0, 1'b1, 12'h010, 32'hA5A5_0001);
        req_valid = 4'b0001; pready = 1'b1; settle();
        chk("t1_ready", req_ready, 4'b0001);
        chk("t1_idle_psel", psel, 0);
        tick(); req_valid = '0; settle();
        chk("t1_setup_psel", psel, 1);
        chk("t1_setup_penable", penable, 0);
        chk("t1_paddr", paddr, 12'h010);
        chk("t1_pwdata", pwdata, 32'hA5A5_0001);
        chk("t1_pwrite", pwrite, 1);
        tick(); settle();
        chk("t1_access_penable", penable, 1);
        chk("t1_no_early_rsp", rsp_valid, 0);
        tick(); settle();
        chk("t1_rsp_valid", rsp_valid, 4'b0001);
        chk("t1_rsp_err", rsp_err, 0);
        chk("t1_rsp_rdata", rsp_rdata, 0);
        chk("t1_idle_after", psel, 0);

        // 2: all requesters valid, grant order 0,1,2,3,0 every two cycles
        do_reset();
        for (int i = 0; i < NR; i++) set_req(i, 1'(i), AW'(12'h100 + i), $urandom);
        req_valid = 4'b1111; pready = 1'b1;
        k = 0; last_t = 0;
        for (int cyc = 0; cyc < 16 && k < 5; cyc++) begin
            settle();
            if (k > 0) chk("t2_no_idle", psel, 1);
            if (req_ready != '0) begin
                chk("t2_grant", req_ready, (1 << (k % NR)));
                if (k > 0) chk("t2_spacing", (cyc - last_t), 2);
                last_t = cyc;
                k++;
            end
            tick();
        end
        chk("t2_accepts", k, 5);
        req_valid = '0;
        repeat (4) tick();

        // 3: req2 read with 5 wait states; pready during SETUP must be ignored
        set_req(2, 1'b0, 12'h044, 32'h0);
        req_valid = 4'b0100; pready = 1'b0; settle();
        chk("t3_ready", req_ready, 4'b0100);
        tick(); req_valid = '0; pready = 1'b1; settle();
        chk("t3_setup_psel", psel, 1);
        chk("t3_setup_penable", penable, 0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pready = (i == 5);
            prdata = (i == 5) ? 32'hDEAD_BEEF : $urandom;
            settle();
            if (penable) acc++;
            chk("t3_paddr_stable", paddr, 12'h044);
            chk("t3_rsp_quiet", rsp_valid, 0);
        end
        tick(); pready = 1'b0; prdata = '0; settle();
        chk("t3_access_len", acc, 6);
        chk("t3_rsp_valid", rsp_valid, 4'b0100);
        chk("t3_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t3_psel_after", psel, 0);

        // 4: reset during ACCESS drops the transfer, then req0 has priority
        set_req(2, 1'b1, 12'h0F0, 32'h1234_5678);
        req_valid = 4'b0100; settle();
        chk("t4_ready", req_ready, 4'b0100);
        tick(); req_valid = '0; settle();
        tick(); settle();
        chk("t4_in_access", penable, 1);
        presetn = 1'b0; #1;
        chk("t4_psel_drop", psel, 0);
        chk("t4_penable_drop", penable, 0);
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            chk("t4_no_rsp_in_rst", rsp_valid, 0);
        end
        presetn = 1'b1;
        set_req(0, 1'b1, 12'h00C, 32'h0000_000C);
        set_req(1, 1'b0, 12'h01C, 32'h0);
        set_req(3, 1'b1, 12'h03C, 32'h0000_003C);
        req_valid = 4'b1011; settle();
        chk("t4_req0_prio", req_ready, 4'b0001);
        chk("t4_no_stale_rsp", rsp_valid, 0);
        tick(); req_valid = 4'b1010; settle();
        tick(); settle();
        chk("t4_grant1", req_ready, 4'b0010);
        tick(); req_valid = 4'b1000; settle();
        chk("t4_rsp0", rsp_valid, 4'b0001);
        tick(); settle();
        chk("t4_grant3", req_ready, 4'b1000);
        tick(); req_valid = '0; settle();
        chk("t4_rsp1", rsp_valid, 4'b0010);
        tick(); settle();
        tick(); settle();
        chk("t4_rsp3", rsp_valid, 4'b1000);
        chk("t4_idle", psel, 0);

        // 6: req1 re-requests in its rsp_valid cycle while req3 arrives -> req3 first
        set_req(1, 1'b0, 12'h0A0, 32'h0);
        req_valid = 4'b0010; settle();
        chk("t6_grant1", req_ready, 4'b0010);
        tick(); req_valid = '0; settle();
        tick(); prdata = 32'h0BAD_F00D; settle();
        tick(); prdata = '0;
        set_req(3, 1'b1, 12'h0B0, 32'h0000_00B0);
        req_valid = 4'b1010; settle();
        chk("t6_rsp1", rsp_valid, 4'b0010);
        chk("t6_rdata", rsp_rdata, 32'h0BAD_F00D);
        chk("t6_fair_grant3", req_ready, 4'b1000);
        tick(); req_valid = 4'b0010; settle();
        tick(); settle();
        chk("t6_grant1_again", req_ready, 4'b0010);
        tick(); req_valid = '0; settle();
        chk("t6_rsp3", rsp_valid, 4'b1000);
        tick(); tick(); settle();
        chk("t6_rsp1_again", rsp_valid, 4'b0010);
        chk("t6_idle", psel, 0);

`ifdef APB_TIMEOUT_EN
        // 5: timeout after 8 ACCESS cycles, then completion exactly on the limit cycle
        set_req(0, 1'b0, 12'h200, 32'h0);
        req_valid = 4'b0001; pready = 1'b0; prdata = 32'h5555_AAAA; settle();
        chk("t5_ready", req_ready, 4'b0001);
        tick(); req_valid = '0; settle();
        for (int i = 1; i <= 8; i++) begin
            tick(); settle();
            chk("t5_access_cycle", penable, 1);
        end
        tick(); settle();
        chk("t5_abort_psel", psel, 0);
        chk("t5_abort_penable", penable, 0);
        if (rsp_valid == '0) begin
            tick(); settle();
        end
        chk("t5_abort_rsp", rsp_valid, 4'b0001);
        chk("t5_abort_err", rsp_err, 1);
        chk("t5_abort_rdata", rsp_rdata, 0);
        tick(); settle();
        set_req(0, 1'b0, 12'h204, 32'h0);
        req_valid = 4'b0001; settle();
        chk("t5b_ready", req_ready, 4'b0001);
        tick(); req_valid = '0; settle();
        for (int i = 1; i <= 8; i++) begin
            tick(); pready = (i == 8); prdata = 32'h600D_0008; settle();
            chk("t5b_access_cycle", penable, 1);
        end
        tick(); pready = 1'b0; settle();
        chk("t5b_rsp", rsp_valid, 4'b0001);
        chk("t5b_err", rsp_err, 0);
        chk("t5b_rdata", rsp_rdata, 32'h600D_0008);
`endif

        // Randomized traffic against a transaction-level model
        do_reset();
        mv = '0; m_last = NR - 1; act = 1'b0; age = 0; rsp_pend = 1'b0;
        cur_owner = 0; cur_wr = 1'b0; cur_addr = '0; cur_wd = '0; rsp_own = 0; rsp_dat = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!mv[i] && $urandom_range(0, 2) == 0) begin
                    m_wr[i]   = 1'($urandom);
                    m_addr[i] = AW'($urandom);
                    m_wd[i]   = $urandom;
                    mv[i]     = 1'b1;
                    set_req(i, m_wr[i], m_addr[i], m_wd[i]);
                end
            end
            req_valid = mv;
            pready = ($urandom_range(0, 3) != 0) || (act && age >= 7);
            prdata = $urandom;
            settle();

            free = !act || (age >= 2 && pready);
            done = act && age >= 2 && pready;
            win = -1;
            for (int j = 1; j <= NR; j++) begin
                if (win < 0 && mv[(m_last + j) % NR]) win = (m_last + j) % NR;
            end
            exp_ready = (free && win >= 0) ? (1 << win) : 0;

            chk("rnd_req_ready", req_ready, exp_ready);
            chk("rnd_psel", psel, (act && age >= 1));
            chk("rnd_penable", penable, (act && age >= 2));
            chk("rnd_rsp_valid", rsp_valid, (rsp_pend ? (1 << rsp_own) : 0));
            if (rsp_pend) chk("rnd_rsp_rdata", rsp_rdata, rsp_dat);
            if (act && age >= 1) begin
                chk("rnd_paddr", paddr, cur_addr);
                chk("rnd_pwrite", pwrite, cur_wr);
                chk("rnd_pwdata", pwdata, cur_wd);
            end

            rsp_pend = done;
            rsp_own  = cur_owner;
            rsp_dat  = cur_wr ? '0 : prdata;
            if (done) act = 1'b0;
            if (exp_ready != 0) begin
                act       = 1'b1;
                age       = 0;
                cur_owner = win;
                cur_wr    = m_wr[win];
                cur_addr  = m_addr[win];
                cur_wd    = m_wd[win];
                m_last    = win;
                mv[win]   = 1'b0;
            end
            if (act) age++;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
